// File: rtl/high_bit_search_pipe.sv
// ---------------------------------------------------------------------------
// high_bit_search_pipe
//   Two-stage pipelined set-bit search. Each accepted word returns the index
//   of its most-significant set bit (in_search_low=0) or its least-significant
//   set bit (in_search_low=1), plus a found flag. The word is split into
//   SEG_WIDTH-bit segments. Stage 1 finds a per-segment hit and a position
//   within that segment. Stage 2 (the output registers) picks the winning
//   segment and combines the two into the final index.
//   Both sides use valid/ready handshakes. A saturating debug counter tracks
//   how many accepted words were all-zero.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      input_data / in_search_low valid
//   in_ready      block can accept input this cycle (combinational)
//   input_data    word to search
//   in_search_low 0 = highest set bit, 1 = lowest set bit
//   out_valid     result valid
//   out_ready     downstream accepts result
//   out_index     bit index found (0 when nothing is set)
//   out_found     input had at least one set bit
//   zero_count    accepted all-zero inputs, saturating
// ---------------------------------------------------------------------------
module high_bit_search_pipe #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned SEG_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned IDX_WIDTH  = $clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] input_data,
  input  logic                   in_search_low,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_index,
  output logic                   out_found,
  output logic [CNT_WIDTH-1:0]   zero_count
);

  localparam int unsigned NUM_SEGS      = INPUT_WIDTH / SEG_WIDTH;
  localparam int unsigned SEG_IDX_WIDTH = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;

  // Reject parameter sets the segmented search cannot represent.
  if (INPUT_WIDTH < 2) begin : g_bad_input_width
    $error("high_bit_search_pipe: INPUT_WIDTH must be at least 2");
  end
  if ((INPUT_WIDTH % SEG_WIDTH) != 0) begin : g_bad_seg_divide
    $error("high_bit_search_pipe: SEG_WIDTH must divide INPUT_WIDTH");
  end
  if ((SEG_WIDTH & (SEG_WIDTH - 1)) != 0) begin : g_bad_seg_pow2
    $error("high_bit_search_pipe: SEG_WIDTH must be a power of two");
  end

  // Position of the highest or lowest set bit inside one segment, 0 if none.
  // Each scan runs toward the wanted end, so the last hit wins.
  function automatic logic [SEG_IDX_WIDTH-1:0] seg_pos(
    input logic [SEG_WIDTH-1:0] bits,
    input logic                 low
  );
    seg_pos = '0;
    if (low) begin
      for (int b = int'(SEG_WIDTH) - 1; b >= 0; b--) begin
        if (bits[b]) seg_pos = SEG_IDX_WIDTH'(b);
      end
    end else begin
      for (int b = 0; b < int'(SEG_WIDTH); b++) begin
        if (bits[b]) seg_pos = SEG_IDX_WIDTH'(b);
      end
    end
  endfunction

  // Handshake / pipeline advance
  logic s1_valid;
  logic s2_adv_c;
  logic s1_adv_c;
  logic in_xfer_c;

  assign s2_adv_c  = !out_valid || out_ready;
  assign s1_adv_c  = !s1_valid || s2_adv_c;
  assign in_ready  = s1_adv_c;
  assign in_xfer_c = in_valid && in_ready;

  // Stage 1 combinational: per-segment hit flag and in-segment position
  logic [NUM_SEGS-1:0]                    seg_any_c;
  logic [NUM_SEGS-1:0][SEG_IDX_WIDTH-1:0] seg_idx_c;

  for (genvar g = 0; g < int'(NUM_SEGS); g++) begin : g_seg
    assign seg_any_c[g] = |input_data[g*SEG_WIDTH +: SEG_WIDTH];
    assign seg_idx_c[g] = seg_pos(input_data[g*SEG_WIDTH +: SEG_WIDTH], in_search_low);
  end

  // Stage 1 registers; the mode bit travels with its data
  logic                                   s1_low;
  logic [NUM_SEGS-1:0]                    s1_seg_any;
  logic [NUM_SEGS-1:0][SEG_IDX_WIDTH-1:0] s1_seg_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_low     <= 1'b0;
      s1_seg_any <= '0;
      s1_seg_idx <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_low     <= in_search_low;
        s1_seg_any <= seg_any_c;
        s1_seg_idx <= seg_idx_c;
      end
    end
  end

  // Stage 2 combinational: pick the winning segment and build the index
  logic [IDX_WIDTH-1:0] sel_index_c;
  logic                 sel_found_c;

  always_comb begin
    sel_index_c = '0;
    sel_found_c = |s1_seg_any;
    if (s1_low) begin
      for (int k = int'(NUM_SEGS) - 1; k >= 0; k--) begin
        if (s1_seg_any[k]) begin
          sel_index_c = IDX_WIDTH'(k * int'(SEG_WIDTH)) + IDX_WIDTH'(s1_seg_idx[k]);
        end
      end
    end else begin
      for (int k = 0; k < int'(NUM_SEGS); k++) begin
        if (s1_seg_any[k]) begin
          sel_index_c = IDX_WIDTH'(k * int'(SEG_WIDTH)) + IDX_WIDTH'(s1_seg_idx[k]);
        end
      end
    end
  end

  // Stage 2 registers = block outputs; they hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_found <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index <= sel_index_c;
        out_found <= sel_found_c;
      end
    end
  end

  // Debug count of accepted all-zero words, stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_count <= '0;
    end else if (in_xfer_c && (input_data == '0) && (zero_count != {CNT_WIDTH{1'b1}})) begin
      zero_count <= zero_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_high_bit_search_pipe.sv
// ---------------------------------------------------------------------------
// tb_high_bit_search_pipe
//   Self-checking bench for high_bit_search_pipe. Three instances: default
//   8/4/16, a 2-bit counter variant for saturation, and a 32/8 wide variant.
//   The expected results come from a plain arithmetic model, which takes
//   floor(log2) of the word or of its isolated lowest set bit, and feeds a
//   FIFO scoreboard.
// ---------------------------------------------------------------------------
module tb_high_bit_search_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid, in_ready, in_search_low;
  logic [7:0]  input_data;
  logic        out_valid, out_ready, out_found;
  logic [2:0]  out_index;
  logic [15:0] zero_count;

  // Saturation instance (CNT_WIDTH=2)
  logic        c_in_valid, c_in_ready, c_low, c_out_valid, c_out_found;
  logic [7:0]  c_data;
  logic [2:0]  c_index;
  logic [1:0]  c_zero_count;

  // Wide instance (32/8)
  logic        w_in_valid, w_in_ready, w_low, w_out_valid, w_out_found;
  logic [31:0] w_data;
  logic [4:0]  w_index;
  logic [15:0] w_zero_count;

  high_bit_search_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .input_data(input_data),
    .in_search_low(in_search_low), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_found(out_found), .zero_count(zero_count)
  );

  high_bit_search_pipe #(.INPUT_WIDTH(8), .SEG_WIDTH(4), .CNT_WIDTH(2)) dut_cnt (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .input_data(c_data),
    .in_search_low(c_low), .out_valid(c_out_valid), .out_ready(1'b1),
    .out_index(c_index), .out_found(c_out_found), .zero_count(c_zero_count)
  );

  high_bit_search_pipe #(.INPUT_WIDTH(32), .SEG_WIDTH(8), .CNT_WIDTH(16)) dut_wide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .input_data(w_data),
    .in_search_low(w_low), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_index(w_index), .out_found(w_out_found), .zero_count(w_zero_count)
  );

  typedef struct {
    int idx;
    bit found;
  } res_t;

  res_t exp_q[$];
  int   model_zeros = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: index of highest (or lowest) set bit via floor(log2)
  function automatic void ref_search(input logic [31:0] d, input bit low,
                                     output int idx, output bit found);
    logic [31:0] v;
    found = (d != 32'd0);
    idx   = 0;
    v     = low ? (d & (~d + 32'd1)) : d;
    if (found) begin
      while (v > 32'd1) begin
        v = v >> 1;
        idx++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score pops/pushes at the negedge, return #1 after posedge
  task automatic cycle(output bit acc);
    res_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_index", out_index, e.idx);
        chk("out_found", out_found, e.found);
      end
    end
    if (acc) begin
      ref_search({24'd0, input_data}, in_search_low, e.idx, e.found);
      exp_q.push_back(e);
      if (input_data == 8'd0 && model_zeros < 65535) model_zeros++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit low, input bit want_ready);
    bit acc;
    acc           = 1'b0;
    in_valid      = 1'b1;
    input_data    = d;
    in_search_low = low;
    #1;
    if (want_ready) chk("in_ready", in_ready, 1);
    for (int i = 0; i < 20 && !acc; i++) cycle(acc);
    if (!acc) chk("push_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) cycle(acc);
    chk("drain_outstanding", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int   e_idx;
    bit   e_found;
    logic [7:0]  t1 [10];
    logic [31:0] wv [4];
    bit          wl [4];

    rst_n = 1'b0;
    in_valid = 1'b0; input_data = '0; in_search_low = 1'b0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_data = '0; c_low = 1'b0;
    w_in_valid = 1'b0; w_data = '0; w_low = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_found", out_found, 0);
    chk("rst_zero_count", zero_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // 1: back-to-back high search, first-word latency, in_ready held high
    t1 = '{8'hDE, 8'h03, 8'hBE, 8'h15, 8'hCA, 8'h24, 8'hBA, 8'h76, 8'hDE, 8'h43};
    push(t1[0], 1'b0, 1'b1);
    chk("lat_edge1_out_valid", out_valid, 0);
    push(t1[1], 1'b0, 1'b1);
    chk("lat_edge2_out_valid", out_valid, 1);
    chk("lat_edge2_out_index", out_index, 7);
    for (int i = 2; i < 10; i++) push(t1[i], 1'b0, 1'b1);
    drain();

    // 2: low search, then per-word mode switch
    push(8'hDE, 1'b1, 1'b1);
    push(8'h03, 1'b1, 1'b1);
    push(8'h24, 1'b1, 1'b1);
    push(8'h40, 1'b1, 1'b1);
    push(8'h24, 1'b1, 1'b1);
    push(8'h24, 1'b0, 1'b1);
    drain();

    // 3: zero inputs and zero_count
    push(8'h00, 1'b0, 1'b1);
    push(8'h00, 1'b0, 1'b1);
    push(8'h00, 1'b0, 1'b1);
    push(8'h80, 1'b0, 1'b1);
    drain();
    chk("zero_count_model", zero_count, model_zeros);
    chk("zero_count_three", zero_count, 3);

    // 3b: 2-bit counter saturates instead of wrapping
    c_in_valid = 1'b1;
    c_data     = 8'h00;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      chk("sat_zero_count", c_zero_count, (n > 3) ? 3 : n);
    end
    c_in_valid = 1'b0;

    // 4: backpressure hold, then ordered release
    out_ready = 1'b0;
    push(8'h15, 1'b0, 1'b1);
    push(8'h24, 1'b0, 1'b1);
    in_valid      = 1'b1;
    input_data    = 8'h43;
    in_search_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_index", out_index, 4);
      chk("bp_hold_found", out_found, 1);
      cycle(acc);
    end
    out_ready = 1'b1;
    push(8'h43, 1'b0, 1'b0);
    drain();

    // 6: wide instance (32-bit, 8-bit segments)
    wv = '{32'h0001_0000, 32'h8000_0001, 32'h8000_0001, 32'h0000_0000};
    wl = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1'b1;
      w_data     = wv[i];
      w_low      = wl[i];
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      chk("wide_lat1_valid", w_out_valid, 0);
      @(posedge clk);
      #1;
      ref_search(wv[i], wl[i], e_idx, e_found);
      chk("wide_out_valid", w_out_valid, 1);
      chk("wide_out_index", w_index, e_idx);
      chk("wide_out_found", w_out_found, e_found);
    end

    // 7: random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      input_data    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_search_low = 1'($urandom);
      out_ready     = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    out_ready = 1'b1;
    drain();
    chk("rand_zero_count", zero_count, model_zeros);

    // 5: asynchronous reset with words in flight
    push(8'h15, 1'b0, 1'b1);
    push(8'h24, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_index", out_index, 0);
    chk("arst_out_found", out_found, 0);
    chk("arst_zero_count", zero_count, 0);
    chk("arst_in_ready", in_ready, 1);
    exp_q.delete();
    model_zeros = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    push(8'h03, 1'b0, 1'b1);
    chk("post_rst_lat1_valid", out_valid, 0);
    cycle(acc);
    chk("post_rst_out_valid2", out_valid, 1);
    chk("post_rst_out_index", out_index, 1);
    chk("post_rst_out_found", out_found, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
